// File: rtl/gshare_bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter, its helpers and FSM states.
// Counter helpers match the cpu_modules pht_inc/pht_dec semantics.
package gshare_bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_CNT_WNT = 2'b01;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  function automatic bp_cnt_t pht_inc(input bp_cnt_t cnt);
    if (cnt == 2'b11) begin
      return 2'b11;
    end else begin
      return cnt + 2'b01;
    end
  endfunction

  function automatic bp_cnt_t pht_dec(input bp_cnt_t cnt);
    if (cnt == 2'b00) begin
      return 2'b00;
    end else begin
      return cnt - 2'b01;
    end
  endfunction

  function automatic bp_cnt_t pht_step(input bp_cnt_t cnt, input logic taken);
    if (taken) begin
      return pht_inc(cnt);
    end else begin
      return pht_dec(cnt);
    end
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 1R1W array of 2-bit counters, combinational read, synchronous write.
// The write port either loads the weakly-not-taken init value or steps the addressed counter.
module gshare_pht
  import gshare_bp_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             init_i,
  input  logic             taken_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [1:0]       rdata_o
);

  localparam int DEPTH = 2 ** IDX_W;

  bp_cnt_t mem_q [DEPTH];
  bp_cnt_t wdata;

  always_comb begin
    if (init_i) begin
      wdata = BP_CNT_WNT;
    end else begin
      wdata = pht_step(mem_q[waddr_i], taken_i);
    end
  end

  // Storage is deliberately unreset; the owner sweeps it after reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch-direction predictor: PC xor global history indexes a 2-bit counter table.
// Optional GSHARE_BYPASS_EN forwards a same-cycle update to a colliding prediction.
module gshare_bp
  import gshare_bp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_req_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_ready_o,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [IDX_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i
);

  bp_state_t        state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic             pred_ready_q, pred_ready_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_ghr_q, pred_ghr_d;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] pht_waddr;
  logic             pht_we;
  logic             pht_init;
  logic [1:0]       rd_cnt;
  bp_cnt_t          pred_cnt;
  logic             accept;
  logic             upd_en;
  logic             unused_pc_bits;

  assign rd_idx  = pred_pc_i[IDX_W+1:2] ^ ghr_q;
  assign upd_idx = upd_pc_i[IDX_W+1:2] ^ upd_ghr_i;
  assign accept  = pred_req_i & pred_ready_q;
  assign upd_en  = upd_valid_i & (state_q == BP_RUN);

  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                            upd_pc_i[XLEN-1:IDX_W+2], upd_pc_i[1:0]};

  always_comb begin
    if (state_q == BP_INIT) begin
      pht_we    = 1'b1;
      pht_init  = 1'b1;
      pht_waddr = init_ptr_q;
    end else begin
      pht_we    = upd_en;
      pht_init  = 1'b0;
      pht_waddr = upd_idx;
    end
  end

  gshare_pht #(
    .IDX_W (IDX_W)
  ) u_pht (
    .clk     (clk),
    .we_i    (pht_we),
    .init_i  (pht_init),
    .taken_i (upd_taken_i),
    .waddr_i (pht_waddr),
    .raddr_i (rd_idx),
    .rdata_o (rd_cnt)
  );

`ifdef GSHARE_BYPASS_EN
  // A colliding update is visible to the prediction as if it had already been written.
  always_comb begin
    if (upd_en && (upd_idx == rd_idx)) begin
      pred_cnt = pht_step(rd_cnt, upd_taken_i);
    end else begin
      pred_cnt = rd_cnt;
    end
  end
`else
  assign pred_cnt = rd_cnt;
`endif

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      BP_INIT: begin
        init_ptr_d = init_ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (init_ptr_q == {IDX_W{1'b1}}) begin
          state_d = BP_RUN;
        end else begin
          state_d = BP_INIT;
        end
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
    pred_ready_d = (state_d == BP_RUN);
  end

  // Mispredict repair wins over the speculative shift; the prediction still sees pre-repair ghr.
  always_comb begin
    pred_valid_d = accept;
    if (accept) begin
      pred_taken_d = pred_cnt[1];
      pred_ghr_d   = ghr_q;
    end else begin
      pred_taken_d = pred_taken_q;
      pred_ghr_d   = pred_ghr_q;
    end

    if (upd_en && upd_mispredict_i) begin
      ghr_d = {upd_ghr_i[IDX_W-2:0], upd_taken_i};
    end else if (accept) begin
      ghr_d = {ghr_q[IDX_W-2:0], pred_cnt[1]};
    end else begin
      ghr_d = ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BP_INIT;
      init_ptr_q   <= {IDX_W{1'b0}};
      ghr_q        <= {IDX_W{1'b0}};
      pred_ready_q <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= {IDX_W{1'b0}};
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      ghr_q        <= ghr_d;
      pred_ready_q <= pred_ready_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  assign pred_ready_o = pred_ready_q;
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_ghr_o   = pred_ghr_q;

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp with a 16-entry table (IDX_W=4); expected values worked by hand.
module tb_gshare_bp;

  localparam int XLEN  = 64;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             pred_req_i;
  logic [XLEN-1:0]  pred_pc_i;
  logic             pred_ready_o;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pred_ghr_o;
  logic             upd_valid_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic [IDX_W-1:0] upd_ghr_i;
  logic             upd_taken_i;
  logic             upd_mispredict_i;

  int tests;
  int fails;

  gshare_bp #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_req_i       (pred_req_i),
    .pred_pc_i        (pred_pc_i),
    .pred_ready_o     (pred_ready_o),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_req_i       = 1'b0;
    pred_pc_i        = 64'h0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = 64'h0;
    upd_ghr_i        = 4'h0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [3:0] g,
                           input logic t, input logic m);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_ghr_i        = g;
    upd_taken_i      = t;
    upd_mispredict_i = m;
    tick();
    idle_inputs();
  endtask

  // One prediction; with keep0 a same-cycle repair (scratch index 0xF) pins ghr back to 0.
  task automatic predict(input logic [63:0] pc, input logic keep0);
    pred_req_i = 1'b1;
    pred_pc_i  = pc;
    if (keep0) begin
      upd_valid_i      = 1'b1;
      upd_pc_i         = 64'h3C;
      upd_ghr_i        = 4'h0;
      upd_taken_i      = 1'b0;
      upd_mispredict_i = 1'b1;
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests++;
    if (pred_ready_o !== 1'b0 || pred_valid_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL reset_vals: ready=%b valid=%b taken=%b ghr=%h required 0 0 0 0",
               pred_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o);
    end
    rst_n            = 1'b1;
    pred_req_i       = 1'b1;
    pred_pc_i        = 64'h100;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 64'h100;
    upd_ghr_i        = 4'h5;
    upd_taken_i      = 1'b1;
    upd_mispredict_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests++;
      if (pred_ready_o !== (i == 15) || pred_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL init_window[%0d]: ready=%b valid=%b required ready=%b valid=0",
                 i, pred_ready_o, pred_valid_o, (i == 15));
      end
    end
    idle_inputs();
  endtask

  task automatic test_first_predict();
    predict(64'h100, 1'b0);
    tests++;
    if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL first_pred: valid=%b taken=%b ghr=%h required 1 0 0",
               pred_valid_o, pred_taken_o, pred_ghr_o);
    end
    tick();
    tests++;
    if (pred_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL no_req_valid: valid=%b required 0", pred_valid_o);
    end
  endtask

  task automatic test_training();
    do_update(64'h100, 4'h0, 1'b1, 1'b0);
    do_update(64'h100, 4'h0, 1'b1, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL train_2t: valid=%b taken=%b ghr=%h required 1 1 0",
               pred_valid_o, pred_taken_o, pred_ghr_o);
    end
    tick();
    tests++;
    if (pred_valid_o !== 1'b0 || pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL hold_taken: valid=%b taken=%b required 0 1", pred_valid_o, pred_taken_o);
    end
    for (int i = 0; i < 5; i++) do_update(64'h100, 4'h0, 1'b1, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL train_sat_hi: taken=%b required 1", pred_taken_o);
    end
    do_update(64'h100, 4'h0, 1'b0, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL train_1nt: taken=%b required 1", pred_taken_o);
    end
    do_update(64'h100, 4'h0, 1'b0, 1'b0);
    do_update(64'h100, 4'h0, 1'b0, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL train_3nt: taken=%b required 0", pred_taken_o);
    end
    // Extra not-taken must stick at 00, so two taken only reach 10.
    do_update(64'h100, 4'h0, 1'b0, 1'b0);
    do_update(64'h100, 4'h0, 1'b1, 1'b0);
    do_update(64'h100, 4'h0, 1'b1, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL train_sat_lo: taken=%b required 1", pred_taken_o);
    end
  endtask

  task automatic test_spec_ghr();
    logic [3:0] exp_g [3];
    logic       exp_t [3];
    exp_g[0] = 4'h0; exp_t[0] = 1'b1;
    exp_g[1] = 4'h1; exp_t[1] = 1'b0;
    exp_g[2] = 4'h2; exp_t[2] = 1'b0;
    pred_req_i = 1'b1;
    pred_pc_i  = 64'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (pred_valid_o !== 1'b1 || pred_ghr_o !== exp_g[i] || pred_taken_o !== exp_t[i]) begin
        fails++;
        $display("FAIL spec_ghr[%0d]: valid=%b ghr=%h taken=%b required 1 %h %b",
                 i, pred_valid_o, pred_ghr_o, pred_taken_o, exp_g[i], exp_t[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_repair();
    pred_req_i       = 1'b1;
    pred_pc_i        = 64'h0;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 64'h0;
    upd_ghr_i        = 4'hA;
    upd_taken_i      = 1'b1;
    upd_mispredict_i = 1'b1;
    tick();
    tests++;
    if (pred_ghr_o !== 4'h4 || pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL repair_same_cycle: ghr=%h taken=%b required 4 0", pred_ghr_o, pred_taken_o);
    end
    upd_valid_i      = 1'b0;
    upd_ghr_i        = 4'h0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b1;
    tick();
    tests++;
    if (pred_ghr_o !== 4'h5 || pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL repair_ghr: ghr=%h taken=%b required 5 0", pred_ghr_o, pred_taken_o);
    end
    upd_mispredict_i = 1'b0;
    tick();
    tests++;
    if (pred_ghr_o !== 4'hA || pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL mispred_no_valid: ghr=%h taken=%b required a 1", pred_ghr_o, pred_taken_o);
    end
    idle_inputs();
    do_update(64'h3C, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_collision();
    logic exp_t;
`ifdef GSHARE_BYPASS_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    pred_req_i  = 1'b1;
    pred_pc_i   = 64'h0C;
    upd_valid_i = 1'b1;
    upd_pc_i    = 64'h0C;
    upd_ghr_i   = 4'h0;
    upd_taken_i = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if (pred_taken_o !== exp_t || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL collision: taken=%b ghr=%h required %b 0", pred_taken_o, pred_ghr_o, exp_t);
    end
    do_update(64'h3C, 4'h0, 1'b0, 1'b1);
    predict(64'h0C, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL collision_written: taken=%b required 1", pred_taken_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_update(64'h100, 4'h0, 1'b1, 1'b0);
    predict(64'h100, 1'b1);
    tests++;
    if (pred_taken_o !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_taken: taken=%b required 1", pred_taken_o);
    end
    rst_n      = 1'b0;
    pred_req_i = 1'b1;
    pred_pc_i  = 64'h100;
    tick();
    tests++;
    if (pred_ready_o !== 1'b0 || pred_valid_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL midrun_reset_vals: ready=%b valid=%b taken=%b ghr=%h required 0 0 0 0",
               pred_ready_o, pred_valid_o, pred_taken_o, pred_ghr_o);
    end
    rst_n = 1'b1;
    idle_inputs();
    n = 0;
    while (pred_ready_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL midrun_init_len: cycles=%0d required 16", n);
    end
    predict(64'h100, 1'b0);
    tests++;
    if (pred_valid_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_ghr_o !== 4'h0) begin
      fails++;
      $display("FAIL post_reset_pred: valid=%b taken=%b ghr=%h required 1 0 0",
               pred_valid_o, pred_taken_o, pred_ghr_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_first_predict();
    test_training();
    test_spec_ghr();
    test_repair();
    test_collision();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
